// File: rtl/ch_avg.sv
// Four-symbol DMRS channel-estimate averager: reads {sym,re} estimates and writes one averaged I/Q per RE.
// Optional CH_AVG_ROUND_EN selects round-half-up instead of floor for the divide-by-4.
module ch_avg #(
   parameter int N_RE = 144,
   parameter int DW   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ch_avg_start,
   output logic          avg_done,
   output logic          busy,
   output logic          est_rd_en,
   output logic [9:0]    est_rd_addr,
   input  logic [DW-1:0] est_rd_re,
   input  logic [DW-1:0] est_rd_im,
   output logic          avg_wr_en,
   output logic [7:0]    avg_wr_addr,
   output logic [DW-1:0] avg_wr_re,
   output logic [DW-1:0] avg_wr_im
);

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, DONE, WAIT_LOW} state_t;

   localparam logic [7:0] LAST_RE = 8'(N_RE - 1);
`ifdef CH_AVG_ROUND_EN
   localparam logic signed [DW+1:0] RND = (DW+2)'(2);
`else
   localparam logic signed [DW+1:0] RND = '0;
`endif

   state_t                 state;
   logic                   flush_cnt;
   logic [1:0]             rd_sym;
   logic [7:0]             rd_re;
   logic                   p_valid;
   logic [1:0]             p_sym;
   logic [7:0]             p_re;
   logic signed [DW+1:0]   acc_re, acc_im;
   logic signed [DW+1:0]   data_re, data_im;
   logic signed [DW+1:0]   sum_re, sum_im;

   assign est_rd_addr = {rd_sym, rd_re};

   // Four DW-bit samples cannot overflow DW+2 bits, and the rounding offset still fits.
   function automatic logic [DW-1:0] scale(input logic signed [DW+1:0] a);
      return DW'((a + RND) >>> 2);
   endfunction

   // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
   always_comb begin
      data_re = $signed({{2{est_rd_re[DW-1]}}, est_rd_re});
      data_im = $signed({{2{est_rd_im[DW-1]}}, est_rd_im});
      sum_re  = (p_sym == 2'd0) ? data_re : acc_re + data_re;
      sum_im  = (p_sym == 2'd0) ? data_im : acc_im + data_im;
   end

   // Read sequencer: sym runs fastest so each RE's four samples arrive back to back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         avg_done  <= 1'b0;
         est_rd_en <= 1'b0;
         rd_sym    <= 2'd0;
         rd_re     <= 8'd0;
         flush_cnt <= 1'b0;
      end else begin
         avg_done <= 1'b0;
         case (state)
            IDLE: if (ch_avg_start) begin
               state     <= RUN;
               busy      <= 1'b1;
               est_rd_en <= 1'b1;
               rd_sym    <= 2'd0;
               rd_re     <= 8'd0;
            end
            RUN: begin
               if (rd_sym == 2'd3 && rd_re == LAST_RE) begin
                  est_rd_en <= 1'b0;
                  flush_cnt <= 1'b0;
                  state     <= FLUSH;
               end else begin
                  rd_sym <= rd_sym + 2'd1;
                  if (rd_sym == 2'd3) rd_re <= rd_re + 8'd1;
               end
            end
            FLUSH: begin
               if (flush_cnt) begin
                  state    <= DONE;
                  avg_done <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  flush_cnt <= 1'b1;
               end
            end
            DONE:     state <= WAIT_LOW;
            WAIT_LOW: if (!ch_avg_start) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // NOTE: the async reset also clears p_valid, so a pass cut short emits no partial write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_valid     <= 1'b0;
         p_sym       <= 2'd0;
         p_re        <= 8'd0;
         acc_re      <= '0;
         acc_im      <= '0;
         avg_wr_en   <= 1'b0;
         avg_wr_addr <= 8'd0;
         avg_wr_re   <= '0;
         avg_wr_im   <= '0;
      end else begin
         p_valid   <= est_rd_en;
         p_sym     <= rd_sym;
         p_re      <= rd_re;
         avg_wr_en <= 1'b0;
         if (p_valid) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
            if (p_sym == 2'd3) begin
               avg_wr_en   <= 1'b1;
               avg_wr_addr <= p_re;
               avg_wr_re   <= scale(sum_re);
               avg_wr_im   <= scale(sum_im);
            end
         end
      end
   end

endmodule
